// File: rtl/lcd_bus_ctrl_if.sv
// Request handshake, status flags and PmodCLP pin bundle for lcd_bus_ctrl.
// The requester uses the master view and the bus sequencer uses the slave view.
interface lcd_bus_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic [7:0] lcd_d;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  modport master (
    output req_valid, req_rs, req_data,
    input  req_ready, busy, done, lcd_d, lcd_rs, lcd_rw, lcd_e
  );

  modport slave (
    input  req_valid, req_rs, req_data,
    output req_ready, busy, done, lcd_d, lcd_rs, lcd_rw, lcd_e
  );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// Write-only HD44780 bus sequencer: power-up hold-off, RS/D setup, E strobe,
// data hold and controller execution wait, all timed by one down-counter.

module lcd_bus_ctrl_chk #(
  parameter int unsigned T_PWRUP     = 32'd1500000,
  parameter int unsigned T_AS        = 32'd10,
  parameter int unsigned T_PW        = 32'd50,
  parameter int unsigned T_H         = 32'd10,
  parameter int unsigned T_EXEC      = 32'd4000,
  parameter int unsigned T_EXEC_LONG = 32'd164000,
  parameter int unsigned CNT_W       = 32'd21
) (
  input logic i_clk
);
  localparam logic [63:0] C_MAX = (64'd1 << CNT_W) - 64'd1;

  localparam bit C_OK =
    (T_PWRUP     >= 32'd1) && (64'(T_PWRUP)     <= C_MAX) &&
    (T_AS        >= 32'd1) && (64'(T_AS)        <= C_MAX) &&
    (T_PW        >= 32'd1) && (64'(T_PW)        <= C_MAX) &&
    (T_H         >= 32'd1) && (64'(T_H)         <= C_MAX) &&
    (T_EXEC      >= 32'd1) && (64'(T_EXEC)      <= C_MAX) &&
    (T_EXEC_LONG >= 32'd1) && (64'(T_EXEC_LONG) <= C_MAX);

  a_params_fit: assert property (@(posedge i_clk) C_OK)
    else $error("lcd_bus_ctrl: a timing parameter is zero or does not fit in CNT_W bits");
endmodule

module lcd_bus_ctrl #(
  parameter int unsigned T_PWRUP     = 32'd1500000,
  parameter int unsigned T_AS        = 32'd10,
  parameter int unsigned T_PW        = 32'd50,
  parameter int unsigned T_H         = 32'd10,
  parameter int unsigned T_EXEC      = 32'd4000,
  parameter int unsigned T_EXEC_LONG = 32'd164000,
  parameter int unsigned CNT_W       = 32'd21
) (
  input logic           sysclk,
  input logic           sysreset,
  lcd_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_PWRUP  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ENABLE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_EXEC   = 3'd5
  } state_t;

  // Counter is loaded with T-1 on entry so each state lasts exactly T cycles.
  localparam logic [CNT_W-1:0] C_PWRUP     = CNT_W'(T_PWRUP - 32'd1);
  localparam logic [CNT_W-1:0] C_AS        = CNT_W'(T_AS - 32'd1);
  localparam logic [CNT_W-1:0] C_PW        = CNT_W'(T_PW - 32'd1);
  localparam logic [CNT_W-1:0] C_H         = CNT_W'(T_H - 32'd1);
  localparam logic [CNT_W-1:0] C_EXEC      = CNT_W'(T_EXEC - 32'd1);
  localparam logic [CNT_W-1:0] C_EXEC_LONG = CNT_W'(T_EXEC_LONG - 32'd1);
  localparam logic [CNT_W-1:0] C_ZERO      = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(32'd1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_lcd_e;
  logic             r_lcd_rs;
  logic [7:0]       r_lcd_d;

  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_exec_load;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03));
  endfunction

  assign w_cnt_zero = (r_cnt == C_ZERO);

  // Execution wait length chosen from the byte latched at accept time.
  always_comb begin
    w_exec_load = C_EXEC;
    if (is_clear_home(r_lcd_rs, r_lcd_d)) begin
      w_exec_load = C_EXEC_LONG;
    end else begin
      w_exec_load = C_EXEC;
    end
  end

  // Sequencer FSM with registered bus and handshake outputs.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      r_state  <= ST_PWRUP;
      r_cnt    <= C_PWRUP;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_lcd_e  <= 1'b0;
      r_lcd_rs <= 1'b0;
      r_lcd_d  <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_PWRUP: begin
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_state  <= ST_SETUP;
            r_cnt    <= C_AS;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_lcd_rs <= bus.req_rs;
            r_lcd_d  <= bus.req_data;
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (w_cnt_zero) begin
            r_state <= ST_ENABLE;
            r_cnt   <= C_PW;
            r_lcd_e <= 1'b1;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        ST_ENABLE: begin
          if (w_cnt_zero) begin
            r_state <= ST_HOLD;
            r_cnt   <= C_H;
            r_lcd_e <= 1'b0;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        ST_HOLD: begin
          if (w_cnt_zero) begin
            r_state <= ST_EXEC;
            r_cnt   <= w_exec_load;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        ST_EXEC: begin
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        default: begin
          r_state <= ST_PWRUP;
          r_cnt   <= C_PWRUP;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_lcd_e <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.lcd_e     = r_lcd_e;
  assign bus.lcd_rs    = r_lcd_rs;
  assign bus.lcd_d     = r_lcd_d;
  assign bus.lcd_rw    = 1'b0;

  lcd_bus_ctrl_chk #(
    .T_PWRUP     (T_PWRUP),
    .T_AS        (T_AS),
    .T_PW        (T_PW),
    .T_H         (T_H),
    .T_EXEC      (T_EXEC),
    .T_EXEC_LONG (T_EXEC_LONG),
    .CNT_W       (CNT_W)
  ) u_chk (
    .i_clk (sysclk)
  );

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Self-checking bench for lcd_bus_ctrl: vector table of single writes with a
// scoreboard queue, plus hand-written back-to-back, ignored-request and reset sequences.
module tb_lcd_bus_ctrl;

  localparam int unsigned P_PWRUP = 32'd20;
  localparam int unsigned P_AS    = 32'd2;
  localparam int unsigned P_PW    = 32'd5;
  localparam int unsigned P_H     = 32'd2;
  localparam int unsigned P_EXEC  = 32'd10;
  localparam int unsigned P_LONG  = 32'd40;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
    int         acc;
  } exp_t;

  logic sysclk   = 1'b0;
  logic sysreset = 1'b1;
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_err    = 0;
  exp_t sb[$];
  vec_t vecs[8];

  lcd_bus_ctrl_if bus();

  lcd_bus_ctrl #(
    .T_PWRUP     (P_PWRUP),
    .T_AS        (P_AS),
    .T_PW        (P_PW),
    .T_H         (P_H),
    .T_EXEC      (P_EXEC),
    .T_EXEC_LONG (P_LONG),
    .CNT_W       (32'd21)
  ) dut (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .bus      (bus)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // {lcd_e, lcd_rs, lcd_rw, done, req_ready, busy, lcd_d}
  function automatic logic [31:0] out_vec();
    return {18'd0, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.done, bus.req_ready, bus.busy, bus.lcd_d};
  endfunction

  task automatic check_reset_vals(input string name);
    chk(name, out_vec(), {18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
  endtask

  // Count edges after reset release until req_ready rises; busy must stay high meanwhile.
  task automatic count_pwrup(input string name);
    int n;
    int busy_low;
    n = 0;
    busy_low = 0;
    while (n < 100) begin
      tick();
      n++;
      if (bus.req_ready === 1'b1) break;
      if (bus.busy !== 1'b1) busy_low++;
    end
    chk(name, 32'(n), 32'd20);
    chk({name, "_busy"}, 32'(busy_low), 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (bus.req_ready !== 1'b1) chk("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  // One complete transfer; optionally pulses a stray 0x55 request in the middle of ENABLE.
  task automatic run_xfer(input string name, input logic rs, input logic [7:0] d,
                          input int lat, input bit inject);
    exp_t e;
    exp_t got;
    int   rel;
    int   e_first;
    int   e_cnt;
    int   e_rise;
    int   bad_data;
    bit   seen_done;
    logic prev_e;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_rs    = rs;
    bus.req_data  = d;
    tick();
    bus.req_valid = 1'b0;
    bus.req_rs    = ~rs;
    bus.req_data  = ~d;
    e.rs   = rs;
    e.data = d;
    e.lat  = lat;
    e.acc  = cyc;
    sb.push_back(e);
    rel = 0;
    e_first = -1;
    e_cnt = 0;
    e_rise = 0;
    bad_data = 0;
    seen_done = 1'b0;
    prev_e = bus.lcd_e;
    if (bus.lcd_d !== d || bus.lcd_rs !== rs) bad_data++;
    chk({name, "_ready_drop"}, 32'(bus.req_ready), 32'd0);
    while (!seen_done && rel < 200) begin
      if (inject && rel == 4) begin
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b1;
        bus.req_data  = 8'h55;
      end else if (inject && rel == 5) begin
        bus.req_valid = 1'b0;
      end
      tick();
      rel = cyc - e.acc;
      if (rel == 1) chk({name, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.lcd_e === 1'b1) begin
        if (e_first < 0) e_first = rel;
        e_cnt++;
        if (prev_e !== 1'b1) e_rise++;
      end
      prev_e = bus.lcd_e;
      if (bus.lcd_d !== d || bus.lcd_rs !== rs) bad_data++;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    bus.req_valid = 1'b0;
    if (!seen_done) begin
      chk({name, "_done_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end else begin
      got = sb.pop_front();
      chk({name, "_latency"}, 32'(rel), 32'(got.lat));
      chk({name, "_ready_at_done"}, 32'(bus.req_ready), 32'd1);
      chk({name, "_e_first"}, 32'(e_first), 32'd2);
      chk({name, "_e_cycles"}, 32'(e_cnt), 32'd5);
      chk({name, "_e_strobes"}, 32'(e_rise), 32'd1);
      chk({name, "_bus_stable"}, 32'(bad_data), 32'd0);
      chk({name, "_bus_value"}, {23'd0, bus.lcd_rs, bus.lcd_d}, {23'd0, got.rs, got.data});
      tick();
      chk({name, "_done_pulse"}, {30'd0, bus.done, bus.req_ready}, {30'd0, 1'b0, 1'b1});
    end
  endtask

  initial begin
    int acc1;
    int acc2;
    int bad;
    int n;
    logic [7:0] prev_d;
    logic prev_e;

    vecs[0] = '{1'b1, 8'h41, 19};
    vecs[1] = '{1'b0, 8'h01, 49};
    vecs[2] = '{1'b0, 8'h38, 19};
    vecs[3] = '{1'b1, 8'h01, 19};
    vecs[4] = '{1'b0, 8'h02, 49};
    vecs[5] = '{1'b0, 8'h03, 49};
    vecs[6] = '{1'b0, 8'h04, 19};
    vecs[7] = '{1'b0, 8'h00, 19};

    bus.req_valid = 1'b0;
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h00;

    // Power-on reset and hold-off.
    sysreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_vals($sformatf("reset_vals_%0d", i));
    end
    sysreset = 1'b0;
    count_pwrup("pwrup_len");
    chk("idle_outputs", out_vec(), {18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});

    for (int i = 0; i < 8; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].rs, vecs[i].data, vecs[i].lat, 1'b0);
    end

    // Stray request while E is high must be ignored.
    run_xfer("ignored_req", 1'b1, 8'h41, 19, 1'b1);
    tick();
    chk("ignored_idle_d", {24'd0, bus.lcd_d}, 32'h41);

    // Back-to-back with req_valid held high.
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h48;
    tick();
    acc1 = cyc;
    bus.req_data = 8'h49;
    chk("b2b_first_d", {24'd0, bus.lcd_d}, 32'h48);
    prev_d = bus.lcd_d;
    prev_e = bus.lcd_e;
    acc2 = -1;
    bad = 0;
    n = 0;
    while (acc2 < 0 && n < 100) begin
      tick();
      n++;
      if (bus.lcd_d !== prev_d) begin
        if (prev_e !== 1'b0 || bus.lcd_e !== 1'b0) bad++;
        if (bus.lcd_d === 8'h49) acc2 = cyc;
        else bad++;
      end
      prev_d = bus.lcd_d;
      prev_e = bus.lcd_e;
    end
    bus.req_valid = 1'b0;
    chk("b2b_spacing", 32'(acc2 - acc1), 32'd20);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (bus.lcd_d !== prev_d) bad++;
      prev_d = bus.lcd_d;
    end
    chk("b2b_second_done", 32'(cyc - acc2), 32'd19);
    chk("b2b_d_changes", 32'(bad), 32'd0);

    // Reset in the middle of ENABLE.
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h38;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst_e_before", 32'(bus.lcd_e), 32'd1);
    sysreset = 1'b1;
    tick();
    check_reset_vals("midrst_vals");
    sysreset = 1'b0;
    count_pwrup("midrst_pwrup_len");

    run_xfer("after_reset", 1'b1, 8'h41, 19, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
